tau_mac_array: RTL

//   Multi-lane temporal (count-driven) multiply-accumulate unit; next generation of the single-lane tau MAC.

---
 rtl/tau_mac_array.sv | 111 +++++++++++
 1 files changed

// File: rtl/tau_mac_array.sv
// Multi-lane count-driven MAC: each lane adds b to its accumulator a times, all lanes in lock-step.
// Define TAU_MAC_SAT_EN to make accumulator adds saturate instead of wrapping.
module tau_mac_array #(
    parameter int LANES     = 2,
    parameter int BITWIDTH  = 8,
    parameter int ACC_GUARD = 4
) (
    input  logic                                         clk,
    input  logic                                         reset_n,
    input  logic                                         start,
    input  logic                                         clear,
    input  logic [LANES*BITWIDTH-1:0]                    a,
    input  logic [LANES*BITWIDTH-1:0]                    b,
    output logic                                         busy,
    output logic                                         mac_valid,
    output logic [LANES*(2*BITWIDTH+ACC_GUARD)-1:0]      mac
);

    localparam int OUT_WIDTH = 2*BITWIDTH + ACC_GUARD;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [BITWIDTH-1:0]  cnt_q [LANES];
    logic [BITWIDTH-1:0]  cnt_d [LANES];
    logic [BITWIDTH-1:0]  b_q   [LANES];
    logic [BITWIDTH-1:0]  b_d   [LANES];
    logic [OUT_WIDTH-1:0] acc_q [LANES];
    logic [OUT_WIDTH-1:0] acc_d [LANES];
`ifdef TAU_MAC_SAT_EN
    logic [OUT_WIDTH:0]   sum   [LANES];
`endif
    logic                 run_done;

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        run_done = 1'b1;
        for (int i = 0; i < LANES; i++) begin
            cnt_d[i] = cnt_q[i];
            b_d[i]   = b_q[i];
            acc_d[i] = acc_q[i];
`ifdef TAU_MAC_SAT_EN
            sum[i]   = {1'b0, acc_q[i]} + (OUT_WIDTH+1)'(b_q[i]);
`endif
        end

        case (state_q)
            ST_IDLE: begin
                // Clear takes effect first, so a simultaneous start accumulates from zero.
                if (clear) begin
                    for (int i = 0; i < LANES; i++) acc_d[i] = '0;
                end
                if (start) begin
                    for (int i = 0; i < LANES; i++) begin
                        cnt_d[i] = a[i*BITWIDTH +: BITWIDTH];
                        b_d[i]   = b[i*BITWIDTH +: BITWIDTH];
                    end
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    if (cnt_q[i] != '0) begin
`ifdef TAU_MAC_SAT_EN
                        acc_d[i] = sum[i][OUT_WIDTH] ? {OUT_WIDTH{1'b1}} : sum[i][OUT_WIDTH-1:0];
`else
                        acc_d[i] = acc_q[i] + OUT_WIDTH'(b_q[i]);
`endif
                        cnt_d[i] = cnt_q[i] - 1'b1;
                    end
                    if (cnt_d[i] != '0) run_done = 1'b0;
                end
                if (run_done) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignment only; the accumulator arrays are
        // reset too, since mac must read zero straight out of reset.
        if (!reset_n) begin
            state_q <= ST_IDLE;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= '0;
                b_q[i]   <= '0;
                acc_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            for (int i = 0; i < LANES; i++) begin
                cnt_q[i] <= cnt_d[i];
                b_q[i]   <= b_d[i];
                acc_q[i] <= acc_d[i];
            end
        end
    end

    assign busy      = (state_q != ST_IDLE);
    assign mac_valid = (state_q == ST_DONE);

    always_comb begin
        mac = '0;
        for (int i = 0; i < LANES; i++) mac[i*OUT_WIDTH +: OUT_WIDTH] = acc_q[i];
    end

endmodule
